// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared types and helpers for the ID->EX stage register.
package id_ex_pipeline_reg_pkg;

   localparam int RD_W = 5;

   // Occupancy encoding: bit0 = main valid, bit1 = skid valid.
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'b00,
      BUF_MAIN  = 2'b01,
      BUF_BOTH  = 2'b11
   } buf_state_e;

   function automatic int payload_w(input int dw, input int cw);
      return 4 * dw + RD_W + cw;
   endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_skid.sv
// Generic two-entry valid/ready skid buffer with a registered in_ready.
module pipe_skid_buffer
   import id_ex_pipeline_reg_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   buf_state_e   state_q;
   buf_state_e   state_d;
   logic [W-1:0] main_q;
   logic [W-1:0] skid_q;
   logic         load_main;
   logic         load_skid;
   logic         main_from_skid;
   logic         accept;
   logic         drain;

   assign in_ready  = ~state_q[1];
   assign out_valid = state_q[0];
   assign out_data  = main_q;
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      unique case (state_q)
         BUF_EMPTY: begin
            if (accept) begin
               load_main = 1'b1;
               state_d   = BUF_MAIN;
            end
         end
         BUF_MAIN: begin
            if (drain && accept) begin
               load_main = 1'b1;
            end else if (drain) begin
               state_d = BUF_EMPTY;
            end else if (accept) begin
               load_skid = 1'b1;
               state_d   = BUF_BOTH;
            end
         end
         BUF_BOTH: begin
            if (drain) begin
               main_from_skid = 1'b1;
               state_d        = BUF_MAIN;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase
      // Payload may go stale on flush; the cleared valids gate it.
      if (flush) begin
         state_d = BUF_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= BUF_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load_main) begin
            main_q <= in_data;
         end else if (main_from_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID->EX stage register: packs the decoded instruction around a skid buffer.
// Optional performance counters are enabled with ID_EX_PERF_CNT_EN.
module id_ex_pipeline_reg
   import id_ex_pipeline_reg_pkg::*;
#(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_rs1_data,
   input  logic [DATA_W-1:0] id_rs2_data,
   input  logic [RD_W-1:0]   id_rd,
   input  logic [CTRL_W-1:0] id_ctrl,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_rs1_data,
   output logic [DATA_W-1:0] ex_rs2_data,
   output logic [RD_W-1:0]   ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_bubble_cnt,
   output logic [31:0]       perf_flush_cnt
`endif
);

   localparam int PW = payload_w(DATA_W, CTRL_W);

   logic [PW-1:0] in_data;
   logic [PW-1:0] out_data;

   assign in_data = {id_pc, id_imm, id_rs1_data,
                     id_rs2_data, id_rd, id_ctrl};

   assign {ex_pc, ex_imm, ex_rs1_data,
           ex_rs2_data, ex_rd, ex_ctrl} = out_data;

   pipe_skid_buffer #(
      .W (PW)
   ) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (id_valid),
      .in_ready  (id_ready),
      .in_data   (in_data),
      .out_valid (ex_valid),
      .out_ready (ex_ready),
      .out_data  (out_data)
   );

`ifdef ID_EX_PERF_CNT_EN
   // Free-running counters, wrapping naturally at 2^32.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perf_stall_cnt  <= '0;
         perf_bubble_cnt <= '0;
         perf_flush_cnt  <= '0;
      end else begin
         if (ex_valid && !ex_ready) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (!ex_valid) begin
            perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
         end
         if (flush) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed self-checking bench for id_ex_pipeline_reg.
module tb_id_ex_pipeline_reg;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_imm;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [4:0]  id_rd;
   logic [15:0] id_ctrl;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [31:0] ex_imm;
   logic [31:0] ex_rs1_data;
   logic [31:0] ex_rs2_data;
   logic [4:0]  ex_rd;
   logic [15:0] ex_ctrl;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_bubble_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_ex_pipeline_reg dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush       (flush),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_pc       (id_pc),
      .id_imm      (id_imm),
      .id_rs1_data (id_rs1_data),
      .id_rs2_data (id_rs2_data),
      .id_rd       (id_rd),
      .id_ctrl     (id_ctrl),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .ex_pc       (ex_pc),
      .ex_imm      (ex_imm),
      .ex_rs1_data (ex_rs1_data),
      .ex_rs2_data (ex_rs2_data),
      .ex_rd       (ex_rd),
      .ex_ctrl     (ex_ctrl)
`ifdef ID_EX_PERF_CNT_EN
      ,
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_bubble_cnt (perf_bubble_cnt),
      .perf_flush_cnt  (perf_flush_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc);
      id_valid    = v;
      id_pc       = pc;
      id_imm      = pc + 32'h0000_1000;
      id_rs1_data = pc ^ 32'hA5A5_0000;
      id_rs2_data = ~pc;
      id_rd       = pc[6:2];
      id_ctrl     = pc[15:0] ^ 16'h00F0;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      flush    = 1'b0;
      ex_ready = 1'b1;
      drive(1'b0, 32'h0);
      tick();
      tick();
      reset_n = 1'b1;
      chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
      chk("rst_ex_pc", ex_pc, 32'd0);
      chk("rst_ex_ctrl", {16'd0, ex_ctrl}, 32'd0);

      // 1: streaming, latency 1, full throughput
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'(i * 4));
         tick();
         chk("stream_valid", {31'd0, ex_valid}, 32'd1);
         chk("stream_pc", ex_pc, 32'(i * 4));
         chk("stream_ready", {31'd0, id_ready}, 32'd1);
      end
      chk("stream_rs1", ex_rs1_data, 32'hA5A5_001C);
      chk("stream_rs2", ex_rs2_data, 32'hFFFF_FFE3);
      chk("stream_rd", {27'd0, ex_rd}, 32'd7);
      drive(1'b0, 32'h0);
      tick();
      chk("stream_end", {31'd0, ex_valid}, 32'd0);

      // 2: back-pressure
      drive(1'b1, 32'h00);
      tick();
      drive(1'b1, 32'h04);
      tick();
      drive(1'b1, 32'h08);
      tick();
      chk("bp_pc08", ex_pc, 32'h08);
      ex_ready = 1'b0;
      drive(1'b1, 32'h0C);
      tick();
      chk("bp_hold_pc", ex_pc, 32'h08);
      chk("bp_ready_lo", {31'd0, id_ready}, 32'd0);
      drive(1'b1, 32'h10);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_stall_pc", ex_pc, 32'h08);
         chk("bp_stall_imm", ex_imm, 32'h0000_1008);
         chk("bp_stall_vld", {31'd0, ex_valid}, 32'd1);
         chk("bp_stall_rdy", {31'd0, id_ready}, 32'd0);
      end
      ex_ready = 1'b1;
      tick();
      chk("bp_out_0c", ex_pc, 32'h0C);
      chk("bp_ready_hi", {31'd0, id_ready}, 32'd1);
      tick();
      chk("bp_out_10", ex_pc, 32'h10);
      chk("bp_out_10v", {31'd0, ex_valid}, 32'd1);
      drive(1'b0, 32'h0);
      tick();
      chk("bp_drained", {31'd0, ex_valid}, 32'd0);

      // 3: flush with both entries full and an incoming instr
      ex_ready = 1'b0;
      drive(1'b1, 32'h20);
      tick();
      drive(1'b1, 32'h24);
      tick();
      chk("fl_full", {31'd0, id_ready}, 32'd0);
      flush = 1'b1;
      drive(1'b1, 32'h28);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0);
      chk("fl_valid", {31'd0, ex_valid}, 32'd0);
      chk("fl_ready", {31'd0, id_ready}, 32'd1);
      ex_ready = 1'b1;
      drive(1'b1, 32'h100);
      tick();
      chk("fl_next_pc", ex_pc, 32'h100);
      chk("fl_next_vld", {31'd0, ex_valid}, 32'd1);
      drive(1'b0, 32'h0);
      tick();
      chk("fl_alone", {31'd0, ex_valid}, 32'd0);

      // 4: reset mid-stall
      ex_ready = 1'b0;
      drive(1'b1, 32'h40);
      tick();
      drive(1'b1, 32'h44);
      tick();
      chk("rs_full", {31'd0, id_ready}, 32'd0);
      reset_n = 1'b0;
      drive(1'b0, 32'h0);
      tick();
      reset_n = 1'b1;
      chk("rs_valid", {31'd0, ex_valid}, 32'd0);
      chk("rs_ctrl", {16'd0, ex_ctrl}, 32'd0);
      chk("rs_imm", ex_imm, 32'd0);
      chk("rs_ready", {31'd0, id_ready}, 32'd1);
      ex_ready = 1'b1;
      drive(1'b1, 32'h48);
      tick();
      chk("rs_resume", ex_pc, 32'h48);
      chk("rs_resume_v", {31'd0, ex_valid}, 32'd1);

      // 5: immediate and control path
      drive(1'b1, 32'h4C);
      id_imm  = 32'hFFFF_F800;
      id_ctrl = 16'h0123;
      tick();
      chk("imm_path", ex_imm, 32'hFFFF_F800);
      chk("ctrl_path", {16'd0, ex_ctrl}, 32'h0000_0123);
      drive(1'b0, 32'h0);
      tick();

`ifdef ID_EX_PERF_CNT_EN
      // 6: performance counters
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      ex_ready = 1'b0;
      drive(1'b1, 32'h0);
      tick();
      drive(1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      ex_ready = 1'b1;
      tick();
      flush = 1'b1;
      tick();
      tick();
      flush = 1'b0;
      chk("perf_stall", perf_stall_cnt, 32'd5);
      chk("perf_flush", perf_flush_cnt, 32'd2);
      chk("perf_bubble", perf_bubble_cnt, 32'd3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
